// File: rtl/vedic_seq_mul_ctrl.sv
// vedic_seq_mul_ctrl: sequential WIDTH x WIDTH unsigned multiplier built around
// a single vedic_two (2x2) cell. Operands are split into 2-bit digits; one digit
// pair is multiplied per cycle and shift-accumulated into a 2*WIDTH accumulator.
// Valid/ready handshakes on both the operand and product sides.
//
// Optional feature macro: VEDIC_SEQ_ZERO_SKIP_EN
//   defined   : a zero operand skips RUN and the product (0) is presented at once
//   undefined : zero operands walk the full digit loop like any other pair

// 2x2 vedic multiplier cell: vertical and crosswise products of two 2-bit digits.
module vedic_two (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic cross_lo;
    logic cross_hi;
    logic cross_carry;
    logic vert_hi;

    // Combine the vertical (a0b0, a1b1) and crosswise (a1b0, a0b1) terms.
    always_comb begin
        cross_lo    = a[1] & b[0];
        cross_hi    = a[0] & b[1];
        cross_carry = cross_lo & cross_hi;
        vert_hi     = a[1] & b[1];
        p[0]        = a[0] & b[0];
        p[1]        = cross_lo ^ cross_hi;
        p[2]        = vert_hi ^ cross_carry;
        p[3]        = vert_hi & cross_carry;
    end

endmodule

module vedic_seq_mul_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    // Number of 2-bit digits per operand and total digit-pair steps.
    localparam int N     = WIDTH / 2;
    localparam int STEPS = N * N;
    localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    out_p_q;
    logic [PW-1:0]    out_p_d;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    k_d;
    logic             out_valid_q;
    logic             out_valid_d;

    int               k_int;
    int               digit_i;
    int               digit_j;
    logic [1:0]       a_dig;
    logic [1:0]       b_dig;
    logic [3:0]       pp;
    logic [PW-1:0]    pp_term;
    logic [PW-1:0]    acc_sum;
    logic             last_step;

    // Decode the step counter into the a-digit index (outer) and b-digit index (inner)
    // and pick out those digits with constant-index selects.
    always_comb begin
        k_int   = int'(k_q);
        digit_i = k_int / N;
        digit_j = k_int % N;
        a_dig   = 2'b00;
        b_dig   = 2'b00;
        for (int d = 0; d < N; d++) begin
            if (digit_i == d) begin
                a_dig = a_q[2*d +: 2];
            end
            if (digit_j == d) begin
                b_dig = b_q[2*d +: 2];
            end
        end
    end

    vedic_two u_cell (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    // Weight the partial product by its digit position and add it to the running sum;
    // the accumulator is wide enough for the full product so this never overflows.
    always_comb begin
        pp_term   = PW'(pp) << (2 * (digit_i + digit_j));
        acc_sum   = acc_q + pp_term;
        last_step = (k_q == KW'(STEPS - 1));
    end

    // Next-state logic for the IDLE -> RUN -> DONE handshake controller.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        k_d         = k_q;
        out_p_d     = out_p_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    acc_d = '0;
                    k_d   = '0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
                    if ((in_a == '0) || (in_b == '0)) begin
                        out_p_d     = '0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end

            RUN: begin
                acc_d = acc_sum;
                k_d   = k_q + KW'(1);
                if (last_step) begin
                    k_d         = '0;
                    out_p_d     = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            out_p_q     <= out_p_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand side only opens in IDLE and stays closed while reset is asserted.
    always_comb begin
        in_ready  = (state_q == IDLE) && rst_n;
        busy      = (state_q != IDLE);
        out_valid = out_valid_q;
        out_p     = out_p_q;
    end

endmodule

// File: tb/tb_vedic_seq_mul_ctrl.sv
// Testbench for vedic_seq_mul_ctrl: directed cases plus randomized operand
// streams checked against a plain-arithmetic product model and a FIFO of
// accepted operand pairs. Latency expectations honour VEDIC_SEQ_ZERO_SKIP_EN.
module tb_vedic_seq_mul_ctrl;

    localparam int W  = 8;
    localparam int W4 = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_p;
    logic          busy;

    logic           in_valid4;
    logic           in_ready4;
    logic [W4-1:0]  in_a4;
    logic [W4-1:0]  in_b4;
    logic           out_valid4;
    logic           out_ready4;
    logic [2*W4-1:0] out_p4;
    logic           busy4;

    int test_count = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    vedic_seq_mul_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    vedic_seq_mul_ctrl #(.WIDTH(W4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_a      (in_a4),
        .in_b      (in_b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_p     (out_p4),
        .busy      (busy4)
    );

    // Reference model: cycles from the accepting edge (counted as 1) to out_valid.
    function automatic int expLatency(input int width, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = width / 2;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
        if ((a == 16'd0) || (b == 16'd0)) begin
            return 1;
        end
`endif
        return n * n + 1;
    endfunction

    function automatic logic [31:0] expProduct(input logic [15:0] a, input logic [15:0] b);
        return 32'(a) * 32'(b);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 8-bit instance with a stall before taking the product.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int hold_cycles);
        int          cycles;
        logic [31:0] expected;
        expected  = expProduct(16'(a), 16'(b));
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        checkOutput("in_ready before accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = W'($urandom);
        cycles   = 1;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        checkOutput($sformatf("latency %02h*%02h", a, b), 32'(cycles), 32'(expLatency(W, 16'(a), 16'(b))));
        checkOutput($sformatf("product %02h*%02h", a, b), 32'(out_p), expected);
        checkOutput("busy in DONE", 32'(busy), 32'd1);
        checkOutput("in_ready in DONE", 32'(in_ready), 32'd0);
        for (int c = 0; c < hold_cycles; c++) begin
            tick();
            checkOutput("held product", 32'(out_p), expected);
            checkOutput("held out_valid", 32'(out_valid), 32'd1);
            checkOutput("in_ready while stalled", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("out_valid after take", 32'(out_valid), 32'd0);
        checkOutput("in_ready after take", 32'(in_ready), 32'd1);
        checkOutput("product retained", 32'(out_p), expected);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected summary");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [2*W-1:0] p_cap;
        logic accept_now;
        logic take_now;
        logic saw_valid;
        int   accepted;
        int   received;
        int   budget;
        int   cycles;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        in_a4      = '0;
        in_b4      = '0;
        out_ready4 = 1'b0;

        // Reset state
        repeat (3) tick();
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_p", 32'(out_p), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("in_ready held low in reset", 32'(in_ready), 32'd0);
        checkOutput("reset out_valid w4", 32'(out_valid4), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready after release", 32'(in_ready), 32'd1);
        tick();

        // Directed transactions
        applyStimulus(8'hFF, 8'hFF, 0);
        applyStimulus(8'h0D, 8'h0B, 5);
        applyStimulus(8'h00, 8'hA5, 1);
        applyStimulus(8'h5A, 8'h00, 0);
        applyStimulus(8'h01, 8'h01, 0);
        applyStimulus(8'h80, 8'hC3, 2);

        // Reset while RUN is at step k=7
        in_a     = 8'h12;
        in_b     = 8'h34;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        checkOutput("busy mid run", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("in_ready during reset", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready after abort", 32'(in_ready), 32'd1);
        checkOutput("busy after abort", 32'(busy), 32'd0);
        checkOutput("out_p cleared by reset", 32'(out_p), 32'd0);
        saw_valid = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (out_valid) begin
                saw_valid = 1'b1;
            end
        end
        checkOutput("no output after abort", 32'(saw_valid), 32'd0);

        // 4-bit instance: 0xF * 0xF
        in_a4     = 4'hF;
        in_b4     = 4'hF;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        cycles    = 1;
        while (!out_valid4 && cycles < 100) begin
            tick();
            cycles++;
        end
        checkOutput("w4 latency", 32'(cycles), 32'(expLatency(W4, 16'hF, 16'hF)));
        checkOutput("w4 product", 32'(out_p4), expProduct(16'hF, 16'hF));
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        checkOutput("w4 out_valid after take", 32'(out_valid4), 32'd0);

        // Randomized stream: in_valid held high, random consumer back-pressure
        accepted = 0;
        received = 0;
        budget   = 0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_valid = 1'b1;
        while (received < 1000 && budget < 60000) begin
            out_ready  = 1'($urandom_range(0, 1));
            accept_now = in_valid && in_ready;
            take_now   = out_valid && out_ready;
            p_cap      = out_p;
            tick();
            budget++;
            if (accept_now) begin
                qa.push_back(in_a);
                qb.push_back(in_b);
                accepted++;
                in_a = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
                in_b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
                in_valid = (accepted < 1000);
            end
            if (take_now) begin
                received++;
                if (qa.size() == 0) begin
                    checkOutput("product without operands", 32'(p_cap), 32'hFFFF_FFFF);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    checkOutput($sformatf("random %02h*%02h", ea, eb), 32'(p_cap), expProduct(16'(ea), 16'(eb)));
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("random products received", 32'(received), 32'd1000);
        checkOutput("random operands accepted", 32'(accepted), 32'd1000);
        checkOutput("no operands left pending", 32'(qa.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
